runway_scheduler: RTL and testbench
===================================

RUNWAY_SCHEDULER -- requirements
Module: runway_scheduler

Interface
REQ-001 Parameter NUM_RWY, default 2: number of runways served, range 1..8.
REQ-002 Parameter OCC_CYCLES, default 15: cycles a runway stays occupied per grant, range 1..255.
REQ-003 Parameter WAIT_DEPTH, default 4: wait-queue capacity in requests, a power of two, minimum 2.
REQ-004 Parameter ID_W, default 4: width of the aircraft identifier.
REQ-005 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port en, input, 1 bit: global enable.
REQ-008 Port req_valid, input, 1 bit: landing request present.
REQ-009 Port req_id, input, ID_W bits: identifier of the requesting aircraft.
REQ-010 Port req_ready, output, 1 bit: request accepted this cycle when high together with req_valid.
REQ-011 Port rwy_close, input, NUM_RWY bits: bit i high marks runway i closed to new assignments.
REQ-012 Port grant_valid, output, 1 bit: one-cycle pulse announcing a runway assignment.
REQ-013 Port grant_rwy, output, clog2(NUM_RWY) bits (minimum 1): index of the assigned runway.
REQ-014 Port grant_id, output, ID_W bits: identifier of the aircraft granted.
REQ-015 Port rwy_busy, output, NUM_RWY bits: bit i high while runway i is occupied.
REQ-016 Port wait_flag, output, 1 bit: high while the wait queue is non-empty.
REQ-017 Port wait_count, output, clog2(WAIT_DEPTH)+1 bits: current number of queued requests.

Function
REQ-018 All outputs SHALL be registered, except req_ready, which SHALL equal en AND NOT(queue full), decoded from registered state.
REQ-019 A runway SHALL be eligible at cycle t when its rwy_busy bit is 0 and its rwy_close bit is 0; the lowest eligible index SHALL win.
REQ-020 The block SHALL make at most one grant per cycle, and the queue head SHALL take priority over a newly accepted request.
REQ-021 Bypass: when the queue is empty, a request is accepted, and an eligible runway exists, the request SHALL be granted directly without entering the queue.
REQ-022 Any other accepted request SHALL be pushed to the queue tail in arrival order.
REQ-023 A push and a head pop in the same cycle SHALL leave wait_count unchanged.
REQ-024 For a grant decided at edge t, grant_valid, grant_rwy and grant_id SHALL be visible after edge t; at the same edge rwy_busy[r] SHALL set and the occupancy counter SHALL load OCC_CYCLES.
REQ-025 The occupancy counter SHALL decrement by 1 each enabled cycle, and rwy_busy SHALL clear at the edge where the counter is 1, so that rwy_busy is high for exactly OCC_CYCLES enabled cycles.
REQ-026 A runway whose busy bit clears at edge t SHALL be eligible for the grant decided at edge t+1, never at edge t.
REQ-027 Asserting rwy_close on a busy runway SHALL NOT shorten its occupancy; the runway only becomes ineligible for new assignments.
REQ-028 With all runways closed, requests SHALL queue until the queue is full, after which req_ready SHALL stay 0.
REQ-029 With en=0, the block SHALL perform no accept, no grant and no queue change, and all occupancy counters SHALL hold; grant_valid SHALL be 0.
REQ-030 Counter widths SHALL be sized from OCC_CYCLES, and no counter SHALL wrap.

Reset
REQ-031 While rst=1, grant_valid, grant_rwy, grant_id, rwy_busy, wait_flag and wait_count SHALL be 0, all occupancy counters SHALL be 0, and queue pointers SHALL be 0.
REQ-032 Reset SHALL override en and abort any queued requests and in-progress occupancy; the first accept SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-033 A shared package runway_pkg SHALL hold the default parameter constants and the index/count width functions.
REQ-034 The wait queue SHALL be a sub-module wait_fifo (synchronous FIFO with push, pop, full, empty and count), parameterised by WAIT_DEPTH and ID_W.

Verification (NUM_RWY=2, OCC_CYCLES=4, WAIT_DEPTH=4, ID_W=4)
REQ-035 Bypass: idle, id=3 valid for 1 cycle -> grant_valid next cycle, grant_rwy=0, grant_id=3; rwy_busy=01 for exactly 4 cycles.
REQ-036 Queueing: ids 1,2,3 on consecutive cycles -> 1->rwy0, 2->rwy1; id 3 waits (wait_count=1), then is granted rwy0 on the cycle after rwy_busy[0] clears.
REQ-037 Full: rwy_close=11, ids 1..5 offered -> 4 accepted, req_ready=0 at count 4; reopening rwy1 grants ids 1,2,3,4 in order, each once rwy1 frees.
REQ-038 Enable freeze: en=0 for 3 cycles mid-occupancy -> rwy_busy is extended by exactly 3 cycles and no grant_valid is seen.
REQ-039 Mid-operation reset: rst pulsed with the queue at 2 and both runways busy -> all outputs are 0 the next cycle, and a fresh request is granted rwy0.

Source files
------------

// File: rtl/runway_pkg.sv
// rtl/runway_pkg.sv - shared defaults and width helpers for the runway scheduler
// Purpose: default parameter values and the index/count/occupancy width functions
//          used by runway_scheduler and wait_fifo.
// Ports:   none (package).
package runway_pkg;

  localparam int DEF_NUM_RWY    = 2;
  localparam int DEF_OCC_CYCLES = 15;
  localparam int DEF_WAIT_DEPTH = 4;
  localparam int DEF_ID_W       = 4;

  // Width of an index into n items; never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a count that must reach depth itself (0..depth inclusive).
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of an occupancy counter that loads occ and counts down to 0.
  function automatic int occ_w(input int occ);
    return $clog2(occ + 1);
  endfunction

endpackage

// File: rtl/wait_fifo.sv
// rtl/wait_fifo.sv - synchronous FIFO holding waiting aircraft identifiers
// Purpose: in-order wait queue of aircraft ids.
// Ports:   clk, rst (sync active-high), push/push_data (write tail),
//          pop (drop head), pop_data (current head), full, empty, count.
module wait_fifo
  import runway_pkg::*;
#(
  parameter int DEPTH = DEF_WAIT_DEPTH,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [ID_W-1:0]           push_data,
  input  logic                      pop,
  output logic [ID_W-1:0]           pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [ID_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      // Depth is a power of two, so pointers wrap naturally.
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/runway_scheduler.sv
// rtl/runway_scheduler.sv - assigns landing requests to free runways
// Purpose: grants each accepted request the lowest open, idle runway, queueing
//          requests that cannot be served at once; tracks runway occupancy.
// Ports:   clk, rst (sync active-high), en (global enable),
//          req_valid/req_id/req_ready (request handshake),
//          rwy_close (per-runway closure), grant_valid/grant_rwy/grant_id
//          (one-cycle grant pulse), rwy_busy (occupancy), wait_flag/wait_count.
module runway_scheduler
  import runway_pkg::*;
#(
  parameter int NUM_RWY    = DEF_NUM_RWY,
  parameter int OCC_CYCLES = DEF_OCC_CYCLES,
  parameter int WAIT_DEPTH = DEF_WAIT_DEPTH,
  parameter int ID_W       = DEF_ID_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           req_valid,
  input  logic [ID_W-1:0]                req_id,
  output logic                           req_ready,
  input  logic [NUM_RWY-1:0]             rwy_close,
  output logic                           grant_valid,
  output logic [idx_w(NUM_RWY)-1:0]      grant_rwy,
  output logic [ID_W-1:0]                grant_id,
  output logic [NUM_RWY-1:0]             rwy_busy,
  output logic                           wait_flag,
  output logic [cnt_w(WAIT_DEPTH)-1:0]   wait_count
);

  localparam int RW = idx_w(NUM_RWY);
  localparam int CW = cnt_w(WAIT_DEPTH);
  localparam int OW = occ_w(OCC_CYCLES);

  logic                grant_valid_q, grant_valid_d;
  logic [RW-1:0]       grant_rwy_q, grant_rwy_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [NUM_RWY-1:0]  rwy_busy_q, rwy_busy_d;
  logic                wait_flag_q, wait_flag_d;
  logic [OW-1:0]       occ_q [NUM_RWY];
  logic [OW-1:0]       occ_d [NUM_RWY];

  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [ID_W-1:0]     head_id;
  logic                push, pop, grant, accept, has_elig;
  logic [NUM_RWY-1:0]  elig;
  logic [RW-1:0]       elig_idx;
  logic [ID_W-1:0]     gid;
  logic [CW-1:0]       count_next;

  wait_fifo #(
    .DEPTH (WAIT_DEPTH),
    .ID_W  (ID_W)
  ) u_wait_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (req_id),
    .pop       (pop),
    .pop_data  (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign req_ready   = en && !fifo_full;
  assign grant_valid = grant_valid_q;
  assign grant_rwy   = grant_rwy_q;
  assign grant_id    = grant_id_q;
  assign rwy_busy    = rwy_busy_q;
  assign wait_flag   = wait_flag_q;
  assign wait_count  = fifo_count;

  always_comb begin
    accept   = req_valid && req_ready;
    // Busy bits are registered, so a runway freed at this edge is only seen next cycle.
    elig     = ~rwy_busy_q & ~rwy_close;
    has_elig = |elig;
    elig_idx = '0;
    for (int i = NUM_RWY - 1; i >= 0; i--) begin
      if (elig[i]) elig_idx = RW'(i);
    end

    push  = 1'b0;
    pop   = 1'b0;
    grant = 1'b0;
    gid   = grant_id_q;
    if (en) begin
      if (!fifo_empty && has_elig) begin
        // Queue head outranks any new arrival, which goes to the tail.
        pop   = 1'b1;
        grant = 1'b1;
        gid   = head_id;
        push  = accept;
      end else if (fifo_empty && accept && has_elig) begin
        grant = 1'b1;
        gid   = req_id;
      end else begin
        push  = accept;
      end
    end

    grant_valid_d = grant;
    grant_rwy_d   = grant ? elig_idx : grant_rwy_q;
    grant_id_d    = grant ? gid : grant_id_q;

    count_next  = fifo_count + CW'(push) - CW'(pop);
    wait_flag_d = (count_next != '0);

    for (int r = 0; r < NUM_RWY; r++) begin
      occ_d[r]      = occ_q[r];
      rwy_busy_d[r] = rwy_busy_q[r];
      if (grant && (elig_idx == RW'(r))) begin
        occ_d[r]      = OW'(OCC_CYCLES);
        rwy_busy_d[r] = 1'b1;
      end else if (en && (occ_q[r] != '0)) begin
        // Closing a busy runway does not touch its countdown.
        occ_d[r] = occ_q[r] - OW'(1);
        if (occ_q[r] == OW'(1)) rwy_busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_valid_q <= 1'b0;
      grant_rwy_q   <= '0;
      grant_id_q    <= '0;
      rwy_busy_q    <= '0;
      wait_flag_q   <= 1'b0;
      for (int r = 0; r < NUM_RWY; r++) occ_q[r] <= '0;
    end else begin
      grant_valid_q <= grant_valid_d;
      grant_rwy_q   <= grant_rwy_d;
      grant_id_q    <= grant_id_d;
      rwy_busy_q    <= rwy_busy_d;
      wait_flag_q   <= wait_flag_d;
      for (int r = 0; r < NUM_RWY; r++) occ_q[r] <= occ_d[r];
    end
  end

endmodule

// File: tb/tb_runway_scheduler.sv
// tb/tb_runway_scheduler.sv - self-checking bench for runway_scheduler
module tb_runway_scheduler;

  logic       clk;
  logic       rst;
  logic       en;
  logic       req_valid;
  logic [3:0] req_id;
  logic       req_ready;
  logic [1:0] rwy_close;
  logic       grant_valid;
  logic [0:0] grant_rwy;
  logic [3:0] grant_id;
  logic [1:0] rwy_busy;
  logic       wait_flag;
  logic [2:0] wait_count;

  int tests = 0;
  int fails = 0;

  runway_scheduler #(
    .NUM_RWY    (2),
    .OCC_CYCLES (4),
    .WAIT_DEPTH (4),
    .ID_W       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_ready   (req_ready),
    .rwy_close   (rwy_close),
    .grant_valid (grant_valid),
    .grant_rwy   (grant_rwy),
    .grant_id    (grant_id),
    .rwy_busy    (rwy_busy),
    .wait_flag   (wait_flag),
    .wait_count  (wait_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       v;
    logic [3:0] id;
    logic [1:0] close;
    logic       gv;
    logic       grwy;
    logic [3:0] gid;
    logic [1:0] busy;
    logic [2:0] wc;
    logic       rdy;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic r, input logic e, input logic v,
                              input logic [3:0] id, input logic [1:0] cl,
                              input logic gv, input logic gr, input logic [3:0] gid,
                              input logic [1:0] bz, input logic [2:0] wc,
                              input logic rdy);
    vec_t t;
    t.rst = r; t.en = e; t.v = v; t.id = id; t.close = cl;
    t.gv = gv; t.grwy = gr; t.gid = gid; t.busy = bz; t.wc = wc; t.rdy = rdy;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; req_valid = 1'b0; req_id = '0; rwy_close = '0;
    step();
    rst = 1'b0;
  endtask

  int         gcount;
  int         g_cyc [8];
  logic [3:0] g_id  [8];
  logic       g_rwy [8];
  int         busy_cnt;
  int         gv_seen;
  int         exp_cyc [5];
  logic [3:0] exp_id  [5];

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = 1'b0; req_id = '0; rwy_close = '0;

    //              rst en v  id  close gv grwy gid busy  wc rdy
    vecs[0]  = mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
    vecs[1]  = mk(0, 1, 1, 3, 2'b00, 1, 0, 3, 2'b01, 0, 1);
    vecs[2]  = mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b01, 0, 1);
    vecs[3]  = mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b01, 0, 1);
    vecs[4]  = mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b01, 0, 1);
    vecs[5]  = mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
    vecs[6]  = mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
    vecs[7]  = mk(0, 1, 1, 1, 2'b00, 1, 0, 1, 2'b01, 0, 1);
    vecs[8]  = mk(0, 1, 1, 2, 2'b00, 1, 1, 2, 2'b11, 0, 1);
    vecs[9]  = mk(0, 1, 1, 3, 2'b00, 0, 0, 0, 2'b11, 1, 1);
    vecs[10] = mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b11, 1, 1);
    vecs[11] = mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b10, 1, 1);
    vecs[12] = mk(0, 1, 0, 0, 2'b00, 1, 0, 3, 2'b01, 0, 1);
    vecs[13] = mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b01, 0, 1);
    vecs[14] = mk(0, 1, 1, 8, 2'b10, 0, 0, 0, 2'b01, 1, 1);
    vecs[15] = mk(0, 1, 0, 0, 2'b00, 1, 1, 8, 2'b11, 0, 1);

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst; en = vecs[i].en; req_valid = vecs[i].v;
      req_id = vecs[i].id; rwy_close = vecs[i].close;
      step();
      check($sformatf("v%0d grant_valid", i), grant_valid, vecs[i].gv);
      check($sformatf("v%0d rwy_busy", i), rwy_busy, vecs[i].busy);
      check($sformatf("v%0d wait_count", i), wait_count, vecs[i].wc);
      check($sformatf("v%0d wait_flag", i), wait_flag, (vecs[i].wc != 0));
      check($sformatf("v%0d req_ready", i), req_ready, vecs[i].rdy);
      if (vecs[i].gv || vecs[i].rst) begin
        check($sformatf("v%0d grant_rwy", i), grant_rwy, vecs[i].grwy);
        check($sformatf("v%0d grant_id", i), grant_id, vecs[i].gid);
      end
    end

    // Full queue with both runways closed, then drain through runway 1.
    do_reset();
    rwy_close = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      req_valid = 1'b1;
      req_id = 4'(k);
      check($sformatf("full ready id%0d", k), req_ready, (k <= 4));
      step();
      check($sformatf("full no grant id%0d", k), grant_valid, 1'b0);
    end
    req_valid = 1'b0;
    check("full wait_count", wait_count, 3'd4);
    check("full wait_flag", wait_flag, 1'b1);
    check("full ready low", req_ready, 1'b0);

    rwy_close = 2'b01;
    gcount = 0;
    for (int c = 0; c < 25; c++) begin
      req_valid = (c == 5);
      req_id = 4'd9;
      step();
      if (grant_valid && gcount < 8) begin
        g_cyc[gcount] = c; g_id[gcount] = grant_id; g_rwy[gcount] = grant_rwy;
        gcount++;
      end
      if (c == 5) check("push+pop wait_count", wait_count, 3'd3);
    end
    req_valid = 1'b0;
    exp_cyc[0] = 0;  exp_id[0] = 4'd1;
    exp_cyc[1] = 5;  exp_id[1] = 4'd2;
    exp_cyc[2] = 10; exp_id[2] = 4'd3;
    exp_cyc[3] = 15; exp_id[3] = 4'd4;
    exp_cyc[4] = 20; exp_id[4] = 4'd9;
    check("drain grant count", gcount, 5);
    for (int j = 0; j < 5; j++) begin
      if (j < gcount) begin
        check($sformatf("drain%0d id", j), g_id[j], exp_id[j]);
        check($sformatf("drain%0d cycle", j), g_cyc[j], exp_cyc[j]);
        check($sformatf("drain%0d rwy", j), g_rwy[j], 1'b1);
      end
    end
    check("drain empty", wait_count, 3'd0);

    // Enable freeze mid-occupancy stretches busy by the frozen cycles.
    do_reset();
    req_valid = 1'b1; req_id = 4'd5;
    step();
    check("freeze grant", grant_valid, 1'b1);
    check("freeze grant rwy", grant_rwy, 1'b0);
    busy_cnt = rwy_busy[0] ? 1 : 0;
    gv_seen = 0;
    req_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      en = !(c >= 1 && c <= 3);
      req_valid = !en;
      req_id = 4'd7;
      step();
      if (rwy_busy[0]) busy_cnt++;
      if (grant_valid) gv_seen++;
    end
    en = 1'b1; req_valid = 1'b0;
    check("freeze busy cycles", busy_cnt, 7);
    check("freeze grants seen", gv_seen, 0);
    check("freeze queue untouched", wait_count, 3'd0);

    // Reset while busy with a non-empty queue.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      req_valid = 1'b1; req_id = 4'(k);
      step();
    end
    req_valid = 1'b0;
    check("prerst wait_count", wait_count, 3'd2);
    check("prerst busy", rwy_busy, 2'b11);
    rst = 1'b1;
    step();
    check("rst grant_valid", grant_valid, 1'b0);
    check("rst grant_rwy", grant_rwy, 1'b0);
    check("rst grant_id", grant_id, 4'd0);
    check("rst rwy_busy", rwy_busy, 2'b00);
    check("rst wait_flag", wait_flag, 1'b0);
    check("rst wait_count", wait_count, 3'd0);
    rst = 1'b0;
    req_valid = 1'b1; req_id = 4'd6;
    step();
    req_valid = 1'b0;
    check("postrst grant_valid", grant_valid, 1'b1);
    check("postrst grant_rwy", grant_rwy, 1'b0);
    check("postrst grant_id", grant_id, 4'd6);
    check("postrst busy", rwy_busy, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
